// File: rtl/float_expand.sv
// rtl/float_expand.sv - widens an IEEE-style float to a format with equal or larger exponent/fraction fields
//
// Purpose: one-cycle registered float widening. Normal, zero, infinity and NaN
// inputs map directly; NaN becomes the canonical quiet NaN. Denormal inputs are
// passed through when the exponent width is unchanged, and are normalized when
// the output exponent is wider. The conversion is always exact.
//
// Ports:
//   clock, reset         - clock; synchronous active-high reset (all outputs 0)
//   in_sign              - input sign
//   in_exponent          - input biased exponent, EXP_IN bits
//   in_fraction          - input fraction, FRAC_IN bits
//   out_sign             - output sign
//   out_exponent         - output biased exponent, EXP_OUT bits
//   out_fraction         - output fraction, FRAC_OUT bits
//   is_inf, is_nan       - input was +/-infinity / NaN
//   is_zero              - input was +/-0
//   is_denormal          - output encoding is denormal
module float_expand #(
  parameter int EXP_IN   = 8,
  parameter int FRAC_IN  = 23,
  parameter int EXP_OUT  = 8,
  parameter int FRAC_OUT = 23
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_sign,
  input  logic [EXP_IN-1:0]   in_exponent,
  input  logic [FRAC_IN-1:0]  in_fraction,
  output logic                out_sign,
  output logic [EXP_OUT-1:0]  out_exponent,
  output logic [FRAC_OUT-1:0] out_fraction,
  output logic                is_inf,
  output logic                is_nan,
  output logic                is_zero,
  output logic                is_denormal
);

  localparam int BIAS_IN   = (1 << (EXP_IN - 1)) - 1;
  localparam int BIAS_OUT  = (1 << (EXP_OUT - 1)) - 1;
  localparam int BIAS_DIFF = BIAS_OUT - BIAS_IN;
  localparam int FRAC_PAD  = FRAC_OUT - FRAC_IN;
  localparam int LZ_W      = $clog2(FRAC_IN + 1);

  // A widened exponent must be able to absorb the full normalization shift of
  // the smallest input denormal, otherwise the result could not be exact.
  generate
    if (EXP_OUT < EXP_IN || FRAC_OUT < FRAC_IN) begin : g_bad_width
      $error("float_expand: output fields must be at least as wide as input fields");
    end
    if (EXP_OUT > EXP_IN && BIAS_DIFF < FRAC_IN) begin : g_bad_bias
      $error("float_expand: exponent widening too small to normalize input denormals");
    end
  endgenerate

  logic exp_zero;
  logic exp_ones;
  logic frac_zero;

  assign exp_zero  = (in_exponent == '0);
  assign exp_ones  = &in_exponent;
  assign frac_zero = (in_fraction == '0);

  // Leading-zero count: the highest set bit is the last one to write lz.
  // All-zero fraction yields FRAC_IN; that case is a zero and never normalized.
  logic [LZ_W-1:0] lz;
  always_comb begin
    lz = LZ_W'(FRAC_IN);
    for (int i = 0; i < FRAC_IN; i++) begin
      if (in_fraction[i]) lz = LZ_W'(FRAC_IN - 1 - i);
    end
  end

  // Shifting out the leading one (lz + 1 places) leaves the normalized fraction.
  logic [LZ_W:0]         shift_amount;
  logic [FRAC_IN-1:0]    norm_fraction;
  logic [FRAC_OUT-1:0]   wide_fraction;
  logic [FRAC_OUT-1:0]   wide_norm_fraction;
  logic [FRAC_OUT-1:0]   qnan_fraction;

  assign shift_amount       = {1'b0, lz} + (LZ_W + 1)'(1);
  assign norm_fraction      = in_fraction << shift_amount;
  assign wide_fraction      = FRAC_OUT'(in_fraction) << FRAC_PAD;
  assign wide_norm_fraction = FRAC_OUT'(norm_fraction) << FRAC_PAD;
  assign qnan_fraction      = FRAC_OUT'(1) << (FRAC_OUT - 1);

  logic                next_sign;
  logic [EXP_OUT-1:0]  next_exponent;
  logic [FRAC_OUT-1:0] next_fraction;
  logic                next_inf;
  logic                next_nan;
  logic                next_zero;
  logic                next_denormal;

  always_comb begin
    next_sign     = in_sign;
    next_exponent = EXP_OUT'(in_exponent) + EXP_OUT'(BIAS_DIFF);
    next_fraction = wide_fraction;
    next_inf      = 1'b0;
    next_nan      = 1'b0;
    next_zero     = 1'b0;
    next_denormal = 1'b0;

    if (exp_ones) begin
      next_exponent = '1;
      if (frac_zero) begin
        next_fraction = '0;
        next_inf      = 1'b1;
      end else begin
        // Payload and sign are dropped in favour of the canonical quiet NaN.
        next_sign     = 1'b0;
        next_fraction = qnan_fraction;
        next_nan      = 1'b1;
      end
    end else if (exp_zero) begin
      if (frac_zero) begin
        next_exponent = '0;
        next_fraction = '0;
        next_zero     = 1'b1;
      end else if (EXP_OUT == EXP_IN) begin
        next_exponent = '0;
        next_fraction = wide_fraction;
        next_denormal = 1'b1;
      end else begin
        next_exponent = EXP_OUT'(BIAS_DIFF) - EXP_OUT'(lz);
        next_fraction = wide_norm_fraction;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_sign     <= 1'b0;
      out_exponent <= '0;
      out_fraction <= '0;
      is_inf       <= 1'b0;
      is_nan       <= 1'b0;
      is_zero      <= 1'b0;
      is_denormal  <= 1'b0;
    end else begin
      out_sign     <= next_sign;
      out_exponent <= next_exponent;
      out_fraction <= next_fraction;
      is_inf       <= next_inf;
      is_nan       <= next_nan;
      is_zero      <= next_zero;
      is_denormal  <= next_denormal;
    end
  end

endmodule

// File: tb/tb_float_expand.sv
// tb/tb_float_expand.sv - directed self-checking bench for float_expand (half->single and single->single)
module tb_float_expand;

  logic clock;
  logic reset;

  // half (5,10) -> single (8,23)
  logic        h_in_sign;
  logic [4:0]  h_in_exponent;
  logic [9:0]  h_in_fraction;
  logic        h_out_sign;
  logic [7:0]  h_out_exponent;
  logic [22:0] h_out_fraction;
  logic        h_is_inf, h_is_nan, h_is_zero, h_is_denormal;

  // single (8,23) -> single (8,23)
  logic        s_in_sign;
  logic [7:0]  s_in_exponent;
  logic [22:0] s_in_fraction;
  logic        s_out_sign;
  logic [7:0]  s_out_exponent;
  logic [22:0] s_out_fraction;
  logic        s_is_inf, s_is_nan, s_is_zero, s_is_denormal;

  int compared;
  int mismatched;

  float_expand #(.EXP_IN(5), .FRAC_IN(10), .EXP_OUT(8), .FRAC_OUT(23)) dut_half (
    .clock        (clock),
    .reset        (reset),
    .in_sign      (h_in_sign),
    .in_exponent  (h_in_exponent),
    .in_fraction  (h_in_fraction),
    .out_sign     (h_out_sign),
    .out_exponent (h_out_exponent),
    .out_fraction (h_out_fraction),
    .is_inf       (h_is_inf),
    .is_nan       (h_is_nan),
    .is_zero      (h_is_zero),
    .is_denormal  (h_is_denormal)
  );

  float_expand #(.EXP_IN(8), .FRAC_IN(23), .EXP_OUT(8), .FRAC_OUT(23)) dut_single (
    .clock        (clock),
    .reset        (reset),
    .in_sign      (s_in_sign),
    .in_exponent  (s_in_exponent),
    .in_fraction  (s_in_fraction),
    .out_sign     (s_out_sign),
    .out_exponent (s_out_exponent),
    .out_fraction (s_out_fraction),
    .is_inf       (s_is_inf),
    .is_nan       (s_is_nan),
    .is_zero      (s_is_zero),
    .is_denormal  (s_is_denormal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Flags packed as {inf, nan, zero, denormal}.
  function automatic logic [31:0] h_word();
    return {h_out_sign, h_out_exponent, h_out_fraction};
  endfunction
  function automatic logic [3:0] h_flags();
    return {h_is_inf, h_is_nan, h_is_zero, h_is_denormal};
  endfunction
  function automatic logic [31:0] s_word();
    return {s_out_sign, s_out_exponent, s_out_fraction};
  endfunction
  function automatic logic [3:0] s_flags();
    return {s_is_inf, s_is_nan, s_is_zero, s_is_denormal};
  endfunction

  task automatic drive_half(input logic [15:0] v);
    {h_in_sign, h_in_exponent, h_in_fraction} = v;
  endtask
  task automatic drive_single(input logic [31:0] v);
    {s_in_sign, s_in_exponent, s_in_fraction} = v;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive_half(16'h3C00);
    drive_single(32'h40490FDB);
    reset = 1'b1;
    step();
    step();
    compared++;
    if (h_word() !== 32'h0 || h_flags() !== 4'b0) begin
      mismatched++;
      $display("FAIL reset_half: got %h flags %b, want 00000000 flags 0000", h_word(), h_flags());
    end
    compared++;
    if (s_word() !== 32'h0 || s_flags() !== 4'b0) begin
      mismatched++;
      $display("FAIL reset_single: got %h flags %b, want 00000000 flags 0000", s_word(), s_flags());
    end
    reset = 1'b0;
  endtask

  task automatic test_half_vectors();
    logic [15:0] vin  [10];
    logic [31:0] vexp [10];
    logic [3:0]  vflg [10];
    vin[0] = 16'h3C00; vexp[0] = 32'h3F800000; vflg[0] = 4'b0000;
    vin[1] = 16'h0001; vexp[1] = 32'h33800000; vflg[1] = 4'b0000;
    vin[2] = 16'h03FF; vexp[2] = 32'h387FC000; vflg[2] = 4'b0000;
    vin[3] = 16'h7C00; vexp[3] = 32'h7F800000; vflg[3] = 4'b1000;
    vin[4] = 16'hFC00; vexp[4] = 32'hFF800000; vflg[4] = 4'b1000;
    vin[5] = 16'hFE01; vexp[5] = 32'h7FC00000; vflg[5] = 4'b0100;
    vin[6] = 16'h8000; vexp[6] = 32'h80000000; vflg[6] = 4'b0010;
    vin[7] = 16'h7BFF; vexp[7] = 32'h477FE000; vflg[7] = 4'b0000;
    vin[8] = 16'h8200; vexp[8] = 32'hB8000000; vflg[8] = 4'b0000;
    vin[9] = 16'h0000; vexp[9] = 32'h00000000; vflg[9] = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      drive_half(vin[i]);
      step();
      compared++;
      if (h_word() !== vexp[i] || h_flags() !== vflg[i]) begin
        mismatched++;
        $display("FAIL half_%h: got %h flags %b, want %h flags %b",
                 vin[i], h_word(), h_flags(), vexp[i], vflg[i]);
      end
    end
  endtask

  task automatic test_same_format();
    logic [31:0] vin  [5];
    logic [31:0] vexp [5];
    logic [3:0]  vflg [5];
    vin[0] = 32'h00000001; vexp[0] = 32'h00000001; vflg[0] = 4'b0001;
    vin[1] = 32'h40490FDB; vexp[1] = 32'h40490FDB; vflg[1] = 4'b0000;
    vin[2] = 32'hFFFFFFFF; vexp[2] = 32'h7FC00000; vflg[2] = 4'b0100;
    vin[3] = 32'hFF800000; vexp[3] = 32'hFF800000; vflg[3] = 4'b1000;
    vin[4] = 32'h807FFFFF; vexp[4] = 32'h807FFFFF; vflg[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      drive_single(vin[i]);
      step();
      compared++;
      if (s_word() !== vexp[i] || s_flags() !== vflg[i]) begin
        mismatched++;
        $display("FAIL single_%h: got %h flags %b, want %h flags %b",
                 vin[i], s_word(), s_flags(), vexp[i], vflg[i]);
      end
    end
  endtask

  // Inputs change every cycle; each edge must show exactly the previous input's result.
  task automatic test_back_to_back();
    logic [15:0] vin  [4];
    logic [31:0] vexp [4];
    vin[0] = 16'h0001; vexp[0] = 32'h33800000;
    vin[1] = 16'hFC00; vexp[1] = 32'hFF800000;
    vin[2] = 16'h3C00; vexp[2] = 32'h3F800000;
    vin[3] = 16'h03FF; vexp[3] = 32'h387FC000;
    drive_half(vin[0]);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) drive_half(vin[i + 1]);
      compared++;
      if (h_word() !== vexp[i]) begin
        mismatched++;
        $display("FAIL back_to_back_%0d: got %h, want %h", i, h_word(), vexp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive_half(16'h3C00);
    step();
    compared++;
    if (h_word() !== 32'h3F800000) begin
      mismatched++;
      $display("FAIL mid_reset_before: got %h, want 3f800000", h_word());
    end
    drive_half(16'h7C00);
    reset = 1'b1;
    step();
    compared++;
    if (h_word() !== 32'h0 || h_flags() !== 4'b0) begin
      mismatched++;
      $display("FAIL mid_reset_cleared: got %h flags %b, want 00000000 flags 0000", h_word(), h_flags());
    end
    reset = 1'b0;
    drive_half(16'h0001);
    step();
    compared++;
    if (h_word() !== 32'h33800000 || h_flags() !== 4'b0) begin
      mismatched++;
      $display("FAIL mid_reset_resume: got %h flags %b, want 33800000 flags 0000", h_word(), h_flags());
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    drive_half(16'h0);
    drive_single(32'h0);
    test_reset();
    test_half_vectors();
    test_same_format();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
